// File: rtl/fpsqrt_operand_front.sv
// Front end of the binary32 square-root unit: accepts and classifies an operand,
// prepares the core's radicand and exponent, bypasses special values and guards the core with a watchdog.
module fpsqrt_operand_front #(
  parameter int TIMEOUT = 63,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        start,
  output logic        negative,
  output logic [24:0] op_mant,
  output logic [7:0]  op_exp,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        invalid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_RESULT} state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_start;
  logic               r_negative;
  logic [24:0]        r_op_mant;
  logic [7:0]         r_op_exp;
  logic               r_out_valid;
  logic [31:0]        r_out_data;
  logic               r_invalid;
  logic               r_timeout;
  logic               r_busy;
  logic [CNT_W-1:0]   r_wd;
  logic               r_special;
  logic [31:0]        r_spec_data;
  logic               r_spec_inv;

  logic               w_sign;
  logic [7:0]         w_exp;
  logic [22:0]        w_frac;
  logic [8:0]         w_exp_sum;
  logic [24:0]        w_mant_base;
  logic               w_special;
  logic [31:0]        w_spec_data;
  logic               w_spec_inv;

  assign w_sign      = in_data[31];
  assign w_exp       = in_data[30:23];
  assign w_frac      = in_data[22:0];
  assign w_exp_sum   = {1'b0, w_exp} + 9'd127;
  assign w_mant_base = {1'b0, 1'b1, w_frac};

  // Classification order matters: zeros/denormals first (keep sign), then NaN, +inf, negatives.
  always_comb begin
    w_special   = 1'b1;
    w_spec_data = 32'h0;
    w_spec_inv  = 1'b0;
    if (w_exp == 8'h00) begin
      w_spec_data = {w_sign, 31'b0};
    end else if (w_exp == 8'hFF && w_frac != 23'h0) begin
      w_spec_data = QNAN;
    end else if (w_exp == 8'hFF && !w_sign) begin
      w_spec_data = PINF;
    end else if (w_sign) begin
      w_spec_data = QNAN;
      w_spec_inv  = 1'b1;
    end else begin
      w_special   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_start     <= 1'b0;
      r_negative  <= 1'b0;
      r_op_mant   <= '0;
      r_op_exp    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_invalid   <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_wd        <= '0;
      r_special   <= 1'b0;
      r_spec_data <= '0;
      r_spec_inv  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state     <= S_DISPATCH;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_start     <= !w_special;
            r_negative  <= w_sign;
            r_op_exp    <= w_exp_sum[8:1];
            // Even biased exponent means an odd unbiased one: pre-shift so the core sees an even exponent.
            r_op_mant   <= w_exp[0] ? w_mant_base : (w_mant_base << 1);
            r_special   <= w_special;
            r_spec_data <= w_spec_data;
            r_spec_inv  <= w_spec_inv;
          end
        end
        S_DISPATCH: begin
          r_start <= 1'b0;
          if (r_special) begin
            r_out_data  <= r_spec_data;
            r_invalid   <= r_spec_inv;
            r_out_valid <= 1'b1;
            r_state     <= S_RESULT;
          end else begin
            r_wd    <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            r_out_data  <= core_result;
            r_out_valid <= 1'b1;
            r_state     <= S_RESULT;
          end else if (r_wd == CNT_W'(TIMEOUT)) begin
            r_out_data  <= QNAN;
            r_timeout   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_RESULT;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_invalid   <= 1'b0;
            r_timeout   <= 1'b0;
            r_negative  <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign start     = r_start;
  assign negative  = r_negative;
  assign op_mant   = r_op_mant;
  assign op_exp    = r_op_exp;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign invalid   = r_invalid;
  assign timeout   = r_timeout;
  assign busy      = r_busy;

endmodule
